// File: rtl/msdap_pkg.sv
// Shared MSDAP constants and the coefficient-store load FSM state type.
package msdap_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_RJ_DEPTH    = 16;
    localparam int DEF_COEFF_DEPTH = 512;
    localparam int DEF_NUM_CH      = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RJ,
        LOAD_COEF,
        LOADED
    } state_t;

endpackage

// File: rtl/coef_ram.sv
// Simple synchronous RAM: one write port, one read port with registered output.
module coef_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata holds while re is low; the read mux upstream relies on that.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/coef_store.sv
// Per-channel rj and coefficient tables: streamed load with valid/ready,
// then addressed reads with one-cycle latency.
module coef_store
    import msdap_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RJ_DEPTH    = DEF_RJ_DEPTH,
    parameter int COEFF_DEPTH = DEF_COEFF_DEPTH,
    parameter int NUM_CH      = DEF_NUM_CH,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW         = $clog2(COEFF_DEPTH),
    localparam int RJ_AW      = (RJ_DEPTH > 1) ? $clog2(RJ_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_done,
    input  logic              rd_en,
    input  logic              rd_sel,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);

    state_t          state, state_next;
    logic [CH_W-1:0] ch;
    logic [AW-1:0]   idx;
    logic            accept, wr, rj_last, coef_last, ch_last;
    logic            rd_ok;
    logic            sel_q, have_q;
    logic [CH_W-1:0] ch_q;

    logic [DATA_W-1:0] rj_q [NUM_CH];
    logic [DATA_W-1:0] cf_q [NUM_CH];

    assign accept    = in_valid && in_ready;
    assign wr        = accept && !load_start;
    assign rj_last   = (32'(idx) == RJ_DEPTH - 1);
    assign coef_last = (32'(idx) == COEFF_DEPTH - 1);
    assign ch_last   = (32'(ch) == NUM_CH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = LOAD_RJ;
        end else begin
            case (state)
                LOAD_RJ:   if (accept && rj_last) state_next = LOAD_COEF;
                LOAD_COEF: if (accept && coef_last) state_next = ch_last ? LOADED : LOAD_RJ;
                default:   ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == LOAD_RJ) || (state == LOAD_COEF);
        load_done = (state == LOADED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= '0;
            idx <= '0;
        end else if (load_start) begin
            ch  <= '0;
            idx <= '0;
        end else if (accept) begin
            case (state)
                LOAD_RJ: idx <= rj_last ? '0 : idx + 1'b1;
                LOAD_COEF: begin
                    if (coef_last) begin
                        idx <= '0;
                        ch  <= ch_last ? '0 : ch + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_ok = (state == LOADED) && (32'(rd_ch) < NUM_CH)
                && (32'(rd_addr) < (rd_sel ? COEFF_DEPTH : RJ_DEPTH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic rj_we, cf_we, rj_re, cf_re;

        assign rj_we = wr && (state == LOAD_RJ)   && (32'(ch) == c);
        assign cf_we = wr && (state == LOAD_COEF) && (32'(ch) == c);
        assign rj_re = rd_en && rd_ok && !rd_sel && (32'(rd_ch) == c);
        assign cf_re = rd_en && rd_ok &&  rd_sel && (32'(rd_ch) == c);

        coef_ram #(.DEPTH(RJ_DEPTH), .WIDTH(DATA_W)) u_rj (
            .clk   (clk),
            .we    (rj_we),
            .waddr (idx[RJ_AW-1:0]),
            .wdata (in_data),
            .re    (rj_re),
            .raddr (rd_addr[RJ_AW-1:0]),
            .rdata (rj_q[c])
        );

        coef_ram #(.DEPTH(COEFF_DEPTH), .WIDTH(DATA_W)) u_cf (
            .clk   (clk),
            .we    (cf_we),
            .waddr (idx),
            .wdata (in_data),
            .re    (cf_re),
            .raddr (rd_addr),
            .rdata (cf_q[c])
        );
    end

    // RAM outputs hold between reads, so muxing them with the registered
    // select gives the "hold last value" behaviour without a data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            have_q   <= 1'b0;
            sel_q    <= 1'b0;
            ch_q     <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            if (rd_en) begin
                have_q <= rd_ok;
                sel_q  <= rd_sel;
                ch_q   <= rd_ch;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (have_q) begin
            rd_data = sel_q ? cf_q[ch_q] : rj_q[ch_q];
        end
    end

endmodule

// File: tb/tb_coef_store.sv
// Scoreboard bench for coef_store: reads push expectations, a negedge monitor pops and compares.
module tb_coef_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        load_done;
    logic        rd_en;
    logic        rd_sel;
    logic [0:0]  rd_ch;
    logic [8:0]  rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_err;

    typedef struct {
        logic        err;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    coef_store #(
        .DATA_W      (16),
        .RJ_DEPTH    (16),
        .COEFF_DEPTH (512),
        .NUM_CH      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_done  (load_done),
        .rd_en      (rd_en),
        .rd_sel     (rd_sel),
        .rd_ch      (rd_ch),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load-stream order model: per channel, RJ_DEPTH rj words then 512 coeff words.
    function automatic logic [15:0] img(input int sel, input int ch, input int addr);
        return 16'h8000 | 16'(ch * 528 + (sel != 0 ? 16 : 0) + addr);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd_valid) begin
                if (q.size() == 0) begin
                    chk("rd_unexpected_valid", 32'(rd_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rd_latency", 32'(cyc), 32'(e.due));
                    chk("rd_err", 32'(rd_err), 32'(e.err));
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("rd_valid_missing", 32'(rd_valid), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input int ch, input int addr, input logic err, input logic [15:0] data);
        exp_t e;
        rd_en   = 1'b1;
        rd_sel  = 1'(sel);
        rd_ch   = 1'(ch);
        rd_addr = 9'(addr);
        e.err   = err;
        e.data  = data;
        e.due   = cyc + 1;
        q.push_back(e);
        tick();
    endtask

    task automatic rd_stop();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("start_load_done_low", 32'(load_done), 32'd0);
        chk("start_in_ready_high", 32'(in_ready), 32'd1);
    endtask

    task automatic load_words(input int n, input bit stall, input bit fixed,
                              input logic [15:0] val, input bit full);
        int w = 0;
        int rcnt = 0;
        int guard = 0;
        bit early = 1'b0;
        bit rdy;
        while (w < n && guard < 10000) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = fixed ? val : (16'h8000 | 16'(w));
            rdy = in_ready;
            if (rdy) rcnt++;
            if (load_done) early = 1'b1;
            tick();
            if (rdy && in_valid) w++;
            guard++;
        end
        in_valid = 1'b0;
        chk("load_words_accepted", 32'(w), 32'(n));
        chk("load_done_early", 32'(early), 32'd0);
        if (full) begin
            chk("load_done_after_last", 32'(load_done), 32'd1);
            chk("in_ready_after_last", 32'(in_ready), 32'd0);
            if (!stall) chk("in_ready_cycles", 32'(rcnt), 32'(n));
        end
    endtask

    task automatic read_all_image();
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < (s != 0 ? 512 : 16); a++)
                    rd(s, c, a, 1'b0, img(s, c, a));
        rd_stop();
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        rd_en = 1'b0;
        rd_sel = 1'b0;
        rd_ch = '0;
        rd_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_err", 32'(rd_err), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 32'(in_ready), 32'd0);
        chk("post_reset_load_done", 32'(load_done), 32'd0);

        // Reads before any load are rejected.
        rd(0, 0, 3, 1'b1, 16'h0000);
        rd(1, 1, 7, 1'b1, 16'h0000);
        rd_stop();

        // Full load without stalls, then directed readback.
        pulse_start();
        load_words(1056, 1'b0, 1'b0, 16'h0, 1'b1);
        rd(0, 0, 3, 1'b0, 16'h8003);
        rd(1, 0, 511, 1'b0, 16'h8000 | 16'd527);
        rd(0, 0, 16, 1'b1, 16'h0000);
        for (int a = 0; a < 16; a++) rd(0, 1, a, 1'b0, 16'h8000 | 16'(528 + a));
        rd(1, 1, 511, 1'b0, 16'h8000 | 16'd1055);
        rd(1, 1, 0, 1'b0, 16'h8000 | 16'd544);
        rd_stop();
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'h8220);

        // Stalled load must give the same image.
        pulse_start();
        load_words(1056, 1'b1, 1'b0, 16'h0, 1'b1);
        read_all_image();

        // Restart mid-load, word in the restart cycle is dropped, then fixed-value load.
        pulse_start();
        load_words(300, 1'b0, 1'b0, 16'h0, 1'b0);
        load_start = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hDEAD;
        tick();
        load_start = 1'b0;
        in_valid = 1'b0;
        load_words(1056, 1'b0, 1'b1, 16'h1234, 1'b1);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < (s != 0 ? 512 : 16); a++)
                    rd(s, c, a, 1'b0, 16'h1234);
        rd_stop();

        // Asynchronous reset in the middle of a load.
        pulse_start();
        load_words(200, 1'b0, 1'b0, 16'h0, 1'b0);
        in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_in_ready", 32'(in_ready), 32'd0);
        chk("async_reset_load_done", 32'(load_done), 32'd0);
        chk("async_reset_rd_data", 32'(rd_data), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (20) begin
            tick();
            chk("after_reset_load_done", 32'(load_done), 32'd0);
        end
        chk("after_reset_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rd(0, 0, 0, 1'b1, 16'h0000);
        rd_stop();

        pulse_start();
        load_words(1056, 1'b0, 1'b0, 16'h0, 1'b1);
        rd(1, 0, 511, 1'b0, 16'h8000 | 16'd527);
        rd(0, 1, 15, 1'b0, 16'h8000 | 16'd543);
        rd_stop();

        repeat (3) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/coef_store.md
# coef_store

Parametrised multi-channel storage for the MSDAP filter tables: per channel, the rj shift-count table and the coefficient table. Tables are loaded once from a word stream with a valid/ready handshake, then served to the filter datapath through a random-access read port with one-cycle latency. This block replaces fixed, hard-initialised tables and auto-increment-only readout with run-time loading, channel selection and addressed reads.

## Interface
- DATA_W, 16, table word width
- RJ_DEPTH, 16, rj entries per channel
- COEFF_DEPTH, 512, coefficient entries per channel
- NUM_CH, 2, channels (stereo)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_start  in  1  one-cycle pulse; starts (or restarts) a full table load
- in_valid  in  1  load word valid
- in_data  in  DATA_W  load word
- in_ready  out  1  block accepts a load word this cycle
- load_done  out  1  all tables loaded; level
- rd_en  in  1  read request
- rd_sel  in  1  0 = rj table, 1 = coefficient table
- rd_ch  in  max(1,$clog2(NUM_CH))  channel
- rd_addr  in  $clog2(COEFF_DEPTH)  entry index
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read word
- rd_err  out  1  accompanies rd_valid; request was rejected

## Operation
- States: IDLE, LOAD_RJ, LOAD_COEF, LOADED.
- Reset: state IDLE; in_ready, load_done, rd_valid, rd_err = 0; rd_data = 0; load counters = 0. Memory contents are not cleared.
- IDLE/LOADED + load_start -> LOAD_RJ, ch = 0, idx = 0, load_done drops to 0 the next cycle.
- In LOAD_RJ/LOAD_COEF, in_ready = 1; a word is accepted when in_valid && in_ready and written to table[ch][idx].
- Load order: ch0 rj[0..RJ_DEPTH-1], ch0 coeff[0..COEFF_DEPTH-1], ch1 rj, ch1 coeff, and so on. Total NUM_CH*(RJ_DEPTH+COEFF_DEPTH) words (1056 at defaults).
- LOAD_RJ -> LOAD_COEF after rj idx RJ_DEPTH-1 is accepted. LOAD_COEF -> LOAD_RJ with ch+1 after coeff idx COEFF_DEPTH-1. After the last coefficient of ch NUM_CH-1, the state goes to LOADED.
- in_valid low stalls the load; no counter moves.
- load_start during a load restarts at ch0 rj[0]. A word accepted in that same cycle is discarded.
- Read: rd_en is sampled every cycle.
  - Rejected, with rd_err = 1 and rd_data = 0, if: state != LOADED, rd_ch >= NUM_CH, or rd_addr >= (rd_sel ? COEFF_DEPTH : RJ_DEPTH).
  - Otherwise rd_data = table[rd_ch][rd_addr], rd_err = 0.
- rd_valid pulses for each rd_en; back-to-back reads are allowed every cycle.
- Without rd_en, rd_data holds its last value.
- Both tables are stored full DATA_W. No sign extension or truncation; the datapath interprets the bits.

## Timing
- Write: word accepted on edge N is readable by an rd_en issued on edge N+1 or later (once LOADED).
- load_done rises on the edge after the final word is accepted, and holds until load_start or reset.
- Read latency: rd_en on edge N -> rd_valid, rd_data, rd_err valid after edge N+1, for one cycle.
- in_ready is a registered function of state only; it does not depend on in_valid.
- Reset asserted mid-load: outputs return to reset values immediately (async). Partially written memory is considered invalid until a full load completes.

## Structure
- Shared package msdap_pkg holds the default DATA_W/RJ_DEPTH/COEFF_DEPTH/NUM_CH constants and the state enum typedef (IDLE, LOAD_RJ, LOAD_COEF, LOADED).
- One sub-module, coef_ram: single-port-write, single-port-read synchronous RAM (DEPTH, WIDTH parameters).
- Instantiate coef_ram twice per channel (rj, coeff) via generate. Control FSM and read mux live in coef_store.

## Test plan
- Reset: hold rst_n = 0 mid-cycle -> all outputs 0 asynchronously; after release in_ready = 0, load_done = 0.
- Full load: pulse load_start, then stream 1056 words with value = 0x8000|index, in_valid always high -> in_ready high for exactly 1056 cycles; load_done = 1 one cycle after the last word.
- Readback of the load above:
  - rd_sel=0, rd_ch=0, addr=3 -> 0x8003.
  - rd_sel=1, rd_ch=0, addr=511 -> 0x8000|527.
  - rd_sel=1, rd_ch=1, addr=0 -> 0x8000|544.
  - All responses arrive one cycle after rd_en; back-to-back reads on every cycle return correct data in order.
- Stalled load: toggle in_valid randomly (50%) -> same memory image as the full-load case; load_done only after word 1056.
- Errors: rd_en before load_done -> rd_err = 1, rd_data = 0. After load, rd_sel=0 with addr=16 -> rd_err = 1. rd_ch=2 -> rd_err = 1.
- Restart and reset: load_start after 300 words, then a full load of value 0x1234 -> every entry reads 0x1234. Separately, rst_n low during the load -> load_done stays 0 until a fresh complete load.
